// File: rtl/trap_ctrl_if.sv
// Signal bundle between trap_ctrl and its pipeline / CSR / fetch neighbours.
// master is the trap sequencer side, slave is the surrounding core.
interface trap_ctrl_if;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        mret_valid;
    logic [31:0] int_pc;
    logic        ctrl_mie;
    logic [2:0]  ctrl_mxie;
    logic [2:0]  ctrl_mxip;
    logic        pipe_empty;
    logic        pipe_stall;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        ctrl_trap;
    logic        ctrl_mret;
    logic [4:0]  trap_info;
    logic [31:0] trap_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    modport master (
        input  exc_valid, exc_cause, exc_pc, mret_valid, int_pc,
        input  ctrl_mie, ctrl_mxie, ctrl_mxip, pipe_empty, csr_rdata, redirect_ready,
        output pipe_stall, csr_raddr, ctrl_trap, ctrl_mret, trap_info, trap_pc,
        output redirect_valid, redirect_pc, busy
    );

    modport slave (
        output exc_valid, exc_cause, exc_pc, mret_valid, int_pc,
        output ctrl_mie, ctrl_mxie, ctrl_mxip, pipe_empty, csr_rdata, redirect_ready,
        input  pipe_stall, csr_raddr, ctrl_trap, ctrl_mret, trap_info, trap_pc,
        input  redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exception / mret / interrupt, drains the
// pipeline, strobes the CSR commit and hands fetch the mtvec/mepc redirect target.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no event in progress, sampling exception/mret/interrupt
// ST_DRAIN    | decision latched, stalling until the pipeline is empty
// ST_COMMIT   | one-cycle ctrl_trap strobe, redirect target captured
// ST_REDIRECT | redirect_valid held until fetch accepts it
module trap_ctrl #(
    parameter bit VECTORED = 1'b1
) (
    input logic          ctrl_clk,
    input logic          ctrl_reset,
    trap_ctrl_if.master  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_COMMIT, ST_REDIRECT} state_e;
    typedef enum logic [1:0] {K_EXC, K_MRET, K_INT} kind_e;

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [4:0]  info_q, info_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rpc_q, rpc_d;

    logic [2:0]  irq_vec;
    logic [3:0]  irq_code;
    logic [31:0] csr_base;

    always_comb begin
        irq_vec  = {3{bus.ctrl_mie}} & bus.ctrl_mxie & bus.ctrl_mxip;
        irq_code = 4'd7;
        if (irq_vec[0]) begin
            irq_code = 4'd11;
        end else if (irq_vec[1]) begin
            irq_code = 4'd3;
        end
        csr_base = {bus.csr_rdata[31:2], 2'b00};

        state_d = state_q;
        kind_d  = kind_q;
        info_d  = info_q;
        pc_d    = pc_q;
        rpc_d   = rpc_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.exc_valid) begin
                    kind_d  = K_EXC;
                    info_d  = {1'b0, bus.exc_cause};
                    pc_d    = bus.exc_pc;
                    state_d = ST_DRAIN;
                end else if (bus.mret_valid) begin
                    kind_d  = K_MRET;
                    info_d  = 5'd0;
                    pc_d    = bus.int_pc;
                    state_d = ST_DRAIN;
                end else if (|irq_vec) begin
                    kind_d  = K_INT;
                    info_d  = {1'b1, irq_code};
                    pc_d    = bus.int_pc;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // An exception still in flight is older than the interrupt point.
                if (bus.exc_valid && kind_q == K_INT) begin
                    kind_d = K_EXC;
                    info_d = {1'b0, bus.exc_cause};
                    pc_d   = bus.exc_pc;
                end
                if (bus.pipe_empty) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (VECTORED && kind_q == K_INT && bus.csr_rdata[1:0] == 2'b01) begin
                    rpc_d = csr_base + {26'd0, info_q[3:0], 2'b00};
                end else begin
                    rpc_d = csr_base;
                end
                state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ctrl_clk) begin
        if (ctrl_reset) begin
            state_q <= ST_IDLE;
            kind_q  <= K_EXC;
            info_q  <= 5'd0;
            pc_q    <= 32'd0;
            rpc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            info_q  <= info_d;
            pc_q    <= pc_d;
            rpc_q   <= rpc_d;
        end
    end

    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.pipe_stall     = (state_q != ST_IDLE);
    assign bus.ctrl_trap      = (state_q == ST_COMMIT);
    assign bus.ctrl_mret      = (state_q == ST_COMMIT) && (kind_q == K_MRET);
    assign bus.csr_raddr      = (kind_q == K_MRET) ? 12'h341 : 12'h305;
    assign bus.trap_info      = info_q;
    assign bus.trap_pc        = pc_q;
    assign bus.redirect_valid = (state_q == ST_REDIRECT);
    assign bus.redirect_pc    = rpc_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed scenarios plus random events, checked
// against a behavioural trap model; a VECTORED=0 twin shares the same stimulus.
module tb_trap_ctrl;
    logic ctrl_clk;
    logic ctrl_reset;

    trap_ctrl_if bus0 ();
    trap_ctrl_if bus1 ();

    trap_ctrl #(.VECTORED(1'b1)) dut_v (.ctrl_clk(ctrl_clk), .ctrl_reset(ctrl_reset), .bus(bus0));
    trap_ctrl #(.VECTORED(1'b0)) dut_d (.ctrl_clk(ctrl_clk), .ctrl_reset(ctrl_reset), .bus(bus1));

    logic [31:0] mtvec;
    logic [31:0] mepc;

    assign bus0.csr_rdata = (bus0.csr_raddr == 12'h341) ? mepc :
                            (bus0.csr_raddr == 12'h305) ? mtvec : 32'hBAD0_0BAD;
    assign bus1.csr_rdata = (bus1.csr_raddr == 12'h341) ? mepc :
                            (bus1.csr_raddr == 12'h305) ? mtvec : 32'hBAD0_0BAD;
    assign bus1.exc_valid      = bus0.exc_valid;
    assign bus1.exc_cause      = bus0.exc_cause;
    assign bus1.exc_pc         = bus0.exc_pc;
    assign bus1.mret_valid     = bus0.mret_valid;
    assign bus1.int_pc         = bus0.int_pc;
    assign bus1.ctrl_mie       = bus0.ctrl_mie;
    assign bus1.ctrl_mxie      = bus0.ctrl_mxie;
    assign bus1.ctrl_mxip      = bus0.ctrl_mxip;
    assign bus1.pipe_empty     = bus0.pipe_empty;
    assign bus1.redirect_ready = bus0.redirect_ready;

    initial ctrl_clk = 1'b0;
    always #5 ctrl_clk = ~ctrl_clk;

    typedef struct {
        logic [4:0]  info;
        logic [31:0] pc;
        logic        mret;
        logic [11:0] raddr;
        logic [31:0] rpc_v;
        logic [31:0] rpc_d;
    } exp_t;

    exp_t sbq[$];
    exp_t rq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_trap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ctrl_clk);
        #1;
    endtask

    // Trap model: priority exc > mret > interrupt (ext 11, sw 3, timer 7);
    // a drain-time exception supersedes a pending interrupt decision.
    function automatic exp_t model(input logic e, input logic m, input logic [3:0] cause,
                                   input logic [31:0] epc, input logic [31:0] ipc,
                                   input logic mie, input logic [2:0] ie, input logic [2:0] ip,
                                   input int repl_at, input logic [3:0] rcause,
                                   input logic [31:0] rpc, output int kind);
        exp_t r;
        int codes[3];
        int code;
        logic [31:0] csr;
        logic [31:0] base;
        codes = '{11, 3, 7};
        code = 0;
        kind = 0;
        r.info = 5'd0;
        r.pc = 32'd0;
        if (e) begin
            kind = 1; r.info = {1'b0, cause}; r.pc = epc;
        end else if (m) begin
            kind = 2; r.info = 5'd0; r.pc = ipc;
        end else if (mie) begin
            for (int i = 0; i < 3; i++) begin
                if (kind == 0 && ie[i] && ip[i]) begin
                    kind = 3; code = codes[i]; r.info = {1'b1, 4'(code)}; r.pc = ipc;
                end
            end
        end
        if (kind == 3 && repl_at != 0) begin
            kind = 1; code = 0; r.info = {1'b0, rcause}; r.pc = rpc;
        end
        csr     = (kind == 2) ? mepc : mtvec;
        r.raddr = (kind == 2) ? 12'h341 : 12'h305;
        r.mret  = (kind == 2);
        base    = csr & 32'hFFFF_FFFC;
        r.rpc_d = base;
        r.rpc_v = (kind == 3 && csr[1:0] == 2'b01) ? base + 32'(code * 4) : base;
        return r;
    endfunction

    // Monitor: pops the scoreboard at each commit strobe and each accepted redirect.
    initial begin
        exp_t e;
        forever begin
            @(negedge ctrl_clk);
            if (bus0.ctrl_trap) begin
                check("trap_width", 32'(prev_trap), 32'd0);
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_trap: got ctrl_trap=1 expected no commit at %0t", $time);
                end else begin
                    e = sbq.pop_front();
                    check("trap_info", 32'(bus0.trap_info), 32'(e.info));
                    check("trap_pc", bus0.trap_pc, e.pc);
                    check("ctrl_mret", 32'(bus0.ctrl_mret), 32'(e.mret));
                    check("csr_raddr", 32'(bus0.csr_raddr), 32'(e.raddr));
                    rq.push_back(e);
                end
            end
            prev_trap = bus0.ctrl_trap;
            if (bus0.redirect_valid && bus0.redirect_ready) begin
                if (rq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_redirect: got redirect expected none at %0t", $time);
                end else begin
                    e = rq.pop_front();
                    check("redirect_pc_vec", bus0.redirect_pc, e.rpc_v);
                    check("redirect_pc_dir", bus1.redirect_pc, e.rpc_d);
                    check("twin_valid", 32'(bus1.redirect_valid), 32'd1);
                end
            end
        end
    end

    task automatic do_txn(input logic e, input logic m, input logic [3:0] cause,
                          input logic [31:0] epc, input logic [31:0] ipc, input logic mie,
                          input logic [2:0] ie, input logic [2:0] ip, input int drain,
                          input int delay, input int repl_at, input logic [3:0] rcause,
                          input logic [31:0] rpc, input logic bp_ip);
        exp_t x;
        int kind;
        int total;
        logic [31:0] held;
        x = model(e, m, cause, epc, ipc, mie, ie, ip, repl_at, rcause, rpc, kind);
        tick();
        bus0.exc_valid = e;  bus0.exc_cause = cause; bus0.exc_pc = epc;
        bus0.mret_valid = m; bus0.int_pc = ipc;
        bus0.ctrl_mie = mie; bus0.ctrl_mxie = ie;   bus0.ctrl_mxip = ip;
        bus0.pipe_empty = 1'b0; bus0.redirect_ready = 1'b0;
        if (kind == 0) begin
            tick();
            bus0.exc_valid = 1'b0; bus0.mret_valid = 1'b0; bus0.ctrl_mxip = 3'b000;
            @(negedge ctrl_clk);
            check("no_event_idle", 32'(bus0.busy), 32'd0);
            return;
        end
        sbq.push_back(x);
        total = drain + 4 + delay;
        held = 32'd0;
        for (int c = 1; c <= total; c++) begin
            tick();
            bus0.exc_valid  = (repl_at != 0 && c == repl_at);
            bus0.exc_cause  = rcause;
            bus0.exc_pc     = rpc;
            bus0.mret_valid = 1'b0;
            if (bp_ip) begin
                bus0.ctrl_mie  = 1'b1;
                bus0.ctrl_mxie = 3'b111;
            end
            bus0.ctrl_mxip = (bp_ip && c >= drain + 3 && c < drain + 3 + delay) ? 3'b111 : 3'b000;
            bus0.pipe_empty     = (c > drain);
            bus0.redirect_ready = (c == drain + 3 + delay);
            @(negedge ctrl_clk);
            check("busy_cycle", 32'(bus0.busy), 32'(c < total));
            check("stall_cycle", 32'(bus0.pipe_stall), 32'(c < total));
            check("trap_cycle", 32'(bus0.ctrl_trap), 32'(c == drain + 2));
            check("rvalid_cycle", 32'(bus0.redirect_valid), 32'(c >= drain + 3 && c < total));
            if (c == drain + 3) held = bus0.redirect_pc;
            if (c > drain + 3 && c < total) check("rpc_stable", bus0.redirect_pc, held);
        end
        bus0.redirect_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t x;
        int kind;
        ctrl_reset = 1'b1;
        mtvec = 32'd0; mepc = 32'd0;
        bus0.exc_valid = 1'b0; bus0.exc_cause = 4'd0; bus0.exc_pc = 32'd0;
        bus0.mret_valid = 1'b0; bus0.int_pc = 32'd0; bus0.ctrl_mie = 1'b0;
        bus0.ctrl_mxie = 3'b000; bus0.ctrl_mxip = 3'b000;
        bus0.pipe_empty = 1'b0; bus0.redirect_ready = 1'b0;
        repeat (3) @(posedge ctrl_clk);
        #1 ctrl_reset = 1'b0;
        @(negedge ctrl_clk);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_stall", 32'(bus0.pipe_stall), 32'd0);
        check("rst_trap", 32'(bus0.ctrl_trap), 32'd0);
        check("rst_raddr", 32'(bus0.csr_raddr), 32'h305);
        check("rst_rvalid", 32'(bus0.redirect_valid), 32'd0);
        check("rst_rpc", bus0.redirect_pc, 32'd0);

        mtvec = 32'h800;
        do_txn(1'b1, 1'b0, 4'd2, 32'h100, 32'h0, 1'b0, 3'b000, 3'b000, 0, 0, 0, 4'd0, 32'h0, 1'b0);
        mtvec = 32'h801;
        do_txn(1'b0, 1'b0, 4'd0, 32'h0, 32'h300, 1'b1, 3'b111, 3'b111, 0, 0, 0, 4'd0, 32'h0, 1'b0);
        mepc = 32'h204;
        do_txn(1'b0, 1'b1, 4'd0, 32'h0, 32'h400, 1'b0, 3'b000, 3'b000, 0, 0, 0, 4'd0, 32'h0, 1'b0);
        mtvec = 32'h901;
        do_txn(1'b0, 1'b0, 4'd0, 32'h0, 32'h500, 1'b1, 3'b100, 3'b100, 5, 0, 3, 4'd4, 32'h480, 1'b0);
        do_txn(1'b0, 1'b0, 4'd0, 32'h0, 32'h540, 1'b1, 3'b100, 3'b100, 5, 0, 0, 4'd0, 32'h0, 1'b0);
        mtvec = 32'hA00;
        do_txn(1'b1, 1'b0, 4'd5, 32'h700, 32'h0, 1'b0, 3'b000, 3'b000, 1, 6, 0, 4'd0, 32'h0, 1'b1);

        // Reset while draining: nothing commits, then the same interrupt is taken again.
        mtvec = 32'h801;
        tick();
        bus0.ctrl_mie = 1'b1; bus0.ctrl_mxie = 3'b111; bus0.ctrl_mxip = 3'b010;
        bus0.int_pc = 32'h600; bus0.pipe_empty = 1'b0;
        tick();
        ctrl_reset = 1'b1;
        @(negedge ctrl_clk);
        check("drain_busy", 32'(bus0.busy), 32'd1);
        tick();
        ctrl_reset = 1'b0;
        bus0.ctrl_mxip = 3'b000;
        @(negedge ctrl_clk);
        check("rstd_busy", 32'(bus0.busy), 32'd0);
        check("rstd_stall", 32'(bus0.pipe_stall), 32'd0);
        check("rstd_trap", 32'(bus0.ctrl_trap), 32'd0);
        check("rstd_info", 32'(bus0.trap_info), 32'd0);
        check("rstd_pc", bus0.trap_pc, 32'd0);
        check("rstd_raddr", 32'(bus0.csr_raddr), 32'h305);
        do_txn(1'b0, 1'b0, 4'd0, 32'h0, 32'h600, 1'b1, 3'b111, 3'b010, 0, 0, 0, 4'd0, 32'h0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic e, m, mie, bp;
            logic [2:0] ie, ip;
            int drain, delay, repl;
            e = ($urandom_range(0, 3) == 0);
            m = ($urandom_range(0, 3) == 0);
            mie = ($urandom_range(0, 3) != 0);
            ie = 3'($urandom);
            ip = 3'($urandom);
            bp = 1'($urandom);
            mtvec = $urandom;
            mepc = $urandom;
            drain = $urandom_range(0, 4);
            delay = $urandom_range(0, 3);
            repl = (drain > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, drain) : 0;
            do_txn(e, m, 4'($urandom), $urandom, $urandom, mie, ie, ip, drain, delay, repl,
                   4'($urandom), $urandom, bp);
        end

        repeat (3) tick();
        check("scoreboard_drained", 32'(sbq.size() + rq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
